// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with registered one-hot grant, owner index, lock and
// an optional hold limit enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter_rr #(
   parameter int Hosts    = 4,
   parameter int MaxHold  = 16,
   localparam int HostIdxW = (Hosts > 1) ? $clog2(Hosts) : 1
) (
   input  logic                clk_in,
   input  logic                reset_in,
   input  logic [Hosts-1:0]    h_req_in,
   input  logic [Hosts-1:0]    h_lock_in,
   output logic [Hosts-1:0]    h_gnt_out,
   output logic                gnt_valid_out,
   output logic [HostIdxW-1:0] sel_out,
   output logic                timeout_out
);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t              state_reg, state_next;
   logic [HostIdxW-1:0] last_reg, last_next;
   logic [HostIdxW-1:0] sel_reg, sel_next;
   logic [Hosts-1:0]    gnt_reg, gnt_next;
   logic                valid_reg, valid_next;

   logic [Hosts-1:0]    cand;
   logic [Hosts-1:0]    win_onehot;
   logic [HostIdxW-1:0] win_idx;
   logic                found;
   logic                keep;
   logic                owner_lock;
   logic                force_rot;

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int CntW = $clog2(MaxHold + 1);
   logic [CntW-1:0] cnt_reg, cnt_next;
   logic            tmo_reg, tmo_next;
`endif

   // The current owner is masked out so a release re-arbitrates only among the others.
   always_comb begin
      cand    = (state_reg == OWNED) ? (h_req_in & ~gnt_reg) : h_req_in;
      found   = 1'b0;
      win_idx = '0;
      for (int k = 1; k <= Hosts; k++) begin
         logic [HostIdxW-1:0] idx_w;
         idx_w = HostIdxW'((int'(last_reg) + k) % Hosts);
         if (!found && cand[idx_w]) begin
            found   = 1'b1;
            win_idx = idx_w;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < Hosts; gi++) begin : g_onehot
         assign win_onehot[gi] = found && (win_idx == HostIdxW'(gi));
      end
   endgenerate

   assign owner_lock = h_lock_in[sel_reg];
   assign keep       = h_req_in[sel_reg] | owner_lock;

`ifdef BUS_ARB_TIMEOUT_EN
   // The counter holds (granted cycles - 1), so MaxHold-1 means MaxHold cycles held.
   assign force_rot = (int'(cnt_reg) >= MaxHold - 1) && !owner_lock && found;
`else
   assign force_rot = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      last_next  = last_reg;
      sel_next   = sel_reg;
      gnt_next   = gnt_reg;
      valid_next = valid_reg;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_next   = cnt_reg;
      tmo_next   = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (found) begin
               state_next = OWNED;
               last_next  = win_idx;
               sel_next   = win_idx;
               gnt_next   = win_onehot;
               valid_next = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
               cnt_next   = '0;
`endif
            end
         end
         OWNED: begin
            if (keep && !force_rot) begin
`ifdef BUS_ARB_TIMEOUT_EN
               if (int'(cnt_reg) < MaxHold) cnt_next = cnt_reg + 1'b1;
`endif
            end else if (found) begin
               last_next  = win_idx;
               sel_next   = win_idx;
               gnt_next   = win_onehot;
               valid_next = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
               cnt_next   = '0;
               // Owner still wanted the bus, so this move was forced.
               tmo_next   = keep;
`endif
            end else begin
               state_next = IDLE;
               sel_next   = '0;
               gnt_next   = '0;
               valid_next = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
               cnt_next   = '0;
`endif
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_reg <= IDLE;
         last_reg  <= HostIdxW'(Hosts - 1);
         sel_reg   <= '0;
         gnt_reg   <= '0;
         valid_reg <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
         cnt_reg   <= '0;
         tmo_reg   <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         last_reg  <= last_next;
         sel_reg   <= sel_next;
         gnt_reg   <= gnt_next;
         valid_reg <= valid_next;
`ifdef BUS_ARB_TIMEOUT_EN
         cnt_reg   <= cnt_next;
         tmo_reg   <= tmo_next;
`endif
      end
   end

   assign h_gnt_out     = gnt_reg;
   assign gnt_valid_out = valid_reg;
   assign sel_out       = sel_reg;

`ifdef BUS_ARB_TIMEOUT_EN
   assign timeout_out = tmo_reg;
`else
   // No hold limit in this build; MaxHold is referenced only to fold to constant 0.
   assign timeout_out = (MaxHold < 0);
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: a 4-host instance (MaxHold=4) and a 1-host instance.
module tb_bus_arbiter_rr;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, lock, gnt;
   logic       valid, tmo;
   logic [1:0] sel;
   logic [0:0] req1, lock1, gnt1, sel1;
   logic       valid1, tmo1;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   bus_arbiter_rr #(.Hosts(4), .MaxHold(4)) dut (
      .clk_in(clk), .reset_in(rst), .h_req_in(req), .h_lock_in(lock),
      .h_gnt_out(gnt), .gnt_valid_out(valid), .sel_out(sel), .timeout_out(tmo)
   );

   bus_arbiter_rr #(.Hosts(1)) dut1 (
      .clk_in(clk), .reset_in(rst), .h_req_in(req1), .h_lock_in(lock1),
      .h_gnt_out(gnt1), .gnt_valid_out(valid1), .sel_out(sel1), .timeout_out(tmo1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("vec %0d %s ok (%0h)", vec_cnt, tag, got);
      end
   endtask

   task automatic expect4(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                          input logic e_tmo);
      check({tag, "_gnt"}, 32'(gnt), 32'(e_gnt));
      check({tag, "_valid"}, 32'(valid), 32'(e_gnt != 4'b0));
      check({tag, "_sel"}, 32'(sel), 32'(e_sel));
      check({tag, "_tmo"}, 32'(tmo), 32'(e_tmo));
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] e;
      logic [1:0] s;
      logic [0:0] seq1 [5];
      seq1 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

      rst = 1'b1; req = '0; lock = '0; req1 = '0; lock1 = '0;
      step(); step();
      expect4("reset", 4'b0000, 2'd0, 1'b0);
      check("reset_gnt1", 32'(gnt1), 32'd0);
      check("reset_sel1", 32'(sel1), 32'd0);
      check("reset_tmo1", 32'(tmo1), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         step();
         expect4("idle", 4'b0000, 2'd0, 1'b0);
      end

      // Host 0 first priority after reset, but only 1 and 3 request.
      req = 4'b1010; step(); expect4("t2_h1", 4'b0010, 2'd1, 1'b0);
      step(); expect4("t2_h1_hold", 4'b0010, 2'd1, 1'b0);
      req = 4'b1000; step(); expect4("t2_h3", 4'b1000, 2'd3, 1'b0);
      req = 4'b0000; step(); expect4("t2_idle", 4'b0000, 2'd0, 1'b0);

      // last=3, so host 0 wins; each owner drops after 2 cycles, reasserts 1 later.
      req = 4'b1111; step(); expect4("t3_first", 4'b0001, 2'd0, 1'b0);
      for (int o = 0; o < 4; o++) begin
         e = 4'(1 << o);
         req = 4'b1111; step(); expect4("t3_hold", e, 2'(o), 1'b0);
         req = 4'b1111 & ~e;
         e = 4'(1 << ((o + 1) % 4));
         s = 2'((o + 1) % 4);
         step(); expect4("t3_move", e, s, 1'b0);
      end
      req = 4'b0000; step(); expect4("t3_idle", 4'b0000, 2'd0, 1'b0);

      // last=0 now: host 2 owns, then holds on lock alone while host 0 waits.
      req = 4'b0100; step(); expect4("t4_h2", 4'b0100, 2'd2, 1'b0);
      req = 4'b0001; lock = 4'b0100;
      for (int i = 0; i < 8; i++) begin
         step(); expect4("t4_lock", 4'b0100, 2'd2, 1'b0);
      end
      lock = 4'b0000; step(); expect4("t4_unlock", 4'b0001, 2'd0, 1'b0);
      req = 4'b0000; lock = 4'b0010; step(); expect4("t4_foreign_lock", 4'b0000, 2'd0, 1'b0);
      lock = 4'b0000; req = 4'b0001; step(); expect4("t4_regrant", 4'b0001, 2'd0, 1'b0);
      lock = 4'b0001; req = 4'b0010; step(); expect4("t4_lock0", 4'b0001, 2'd0, 1'b0);
      rst = 1'b1; step(); expect4("t4_reset", 4'b0000, 2'd0, 1'b0);
      rst = 1'b0; lock = 4'b0000; req = 4'b0000;
      step(); expect4("t4_after_rst", 4'b0000, 2'd0, 1'b0);

      // Host 0 holds with host 3 waiting; MaxHold=4 on this instance.
      req = 4'b1001;
      for (int c = 1; c <= 6; c++) begin
         step();
`ifdef BUS_ARB_TIMEOUT_EN
         if (c <= 4)      expect4("t5_hold", 4'b0001, 2'd0, 1'b0);
         else if (c == 5) expect4("t5_timeout", 4'b1000, 2'd3, 1'b1);
         else             expect4("t5_after", 4'b1000, 2'd3, 1'b0);
`else
         expect4("t5_nolimit", 4'b0001, 2'd0, 1'b0);
`endif
      end
      req = 4'b0000; rst = 1'b1; step(); rst = 1'b0;
      req = 4'b1001; lock = 4'b0001;
      for (int c = 1; c <= 6; c++) begin
         step(); expect4("t5_locked", 4'b0001, 2'd0, 1'b0);
      end
      req = 4'b0000; lock = 4'b0000; step(); expect4("t5_idle", 4'b0000, 2'd0, 1'b0);

      // Single host: grant tracks request one edge later.
      for (int i = 0; i < 5; i++) begin
         req1 = seq1[i];
         step();
         check("t6_gnt1", 32'(gnt1), 32'(seq1[i]));
         check("t6_valid1", 32'(valid1), 32'(seq1[i]));
         check("t6_sel1", 32'(sel1), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
